// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // 32-bit modulo increment; 32'hFFFF_FFFC wraps to 0 with no flag.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise hold.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc4_d,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    logic [31:0] instr_p1;
    logic [31:0] pc4_p1;
    logic        vld_p1;

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            instr_p1 <= NOP_INSTR;
            pc4_p1   <= 32'h0000_0000;
            vld_p1   <= 1'b0;
        end else if (load) begin
            instr_p1 <= instr_d;
            pc4_p1   <= pc4_d;
            vld_p1   <= 1'b1;
        end
    end

    assign if_id_instr = instr_p1;
    assign if_id_pc4   = pc4_p1;
    assign if_id_valid = vld_p1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALT control, IF/ID register and fetch counter.
// Define FETCH_DELAY_SLOT_EN to keep the branch delay-slot instruction on redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    input  logic             halt,
    output logic [31:0]      read_address,
    input  logic [31:0]      instruction,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic             halted
);

    localparam logic [31:0] BOOT_PC = RESET_PC & 32'hFFFF_FFFC;

    fetch_state_t     state, state_next;
    logic [31:0]      pc_p0;
    logic [31:0]      pc4;
    logic [31:0]      pc_next;
    logic             ifid_load;
    logic             ifid_bubble;
    logic [CNT_W-1:0] count_q;

    assign pc4 = pc_plus4(pc_p0);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_BOOT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  state_next = halt ? ST_HALT : ST_RUN;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_BOOT;
        endcase
    end

    // RUN priority: halt > redirect > stall > flush > normal fetch.
    always_comb begin
        pc_next     = pc_p0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt) begin
                    ifid_bubble = 1'b1;
                end else if (redirect_valid) begin
                    pc_next = redirect_target & 32'hFFFF_FFFC;
`ifdef FETCH_DELAY_SLOT_EN
                    ifid_load = 1'b1;
`else
                    ifid_bubble = 1'b1;
`endif
                end else if (stall) begin
                    pc_next = pc_p0;
                end else if (flush) begin
                    pc_next     = pc4;
                    ifid_bubble = 1'b1;
                end else begin
                    pc_next   = pc4;
                    ifid_load = 1'b1;
                end
            end
            default: ifid_bubble = 1'b1;
        endcase
    end

    // PC stage boundary
    always_ff @(posedge clk) begin
        if (reset) pc_p0 <= BOOT_PC;
        else       pc_p0 <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (reset)          count_q <= '0;
        else if (ifid_load) count_q <= count_q + CNT_W'(1);
    end

    if_id_reg u_if_id (
        .clk         (clk),
        .reset       (reset),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .instr_d     (instruction),
        .pc4_d       (pc4),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );

    assign read_address = pc_p0;
    assign fetch_count  = count_q;
    assign halted       = (state == ST_HALT);

endmodule
